// File: rtl/data_mem_param_pkg.sv
// data_mem_param_pkg: shared size codes, FSM states and LED address default
package data_mem_param_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;
  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h2000;
endpackage

// File: rtl/data_mem_param_lane_fmt.sv
// data_mem_param_lane_fmt: lane select/extend for loads, lane merge for stores, alignment check
module data_mem_param_lane_fmt
  import data_mem_param_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] store,
  output logic [31:0] load,
  output logic [31:0] merged,
  output logic        misaligned
);
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask;
  always_comb begin
    sh = {offset, 3'b000};
    b = word[sh +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    load = size == SZ_BYTE ? {{24{sign & b[7]}}, b} :
           size == SZ_HALF ? {{16{sign & h[15]}}, h} : word;
    mask = size == SZ_BYTE ? 32'h0000_00FF << sh :
           size == SZ_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    merged = (word & ~mask) | ((store << sh) & mask);
    misaligned = !(size == SZ_BYTE || (size == SZ_HALF && !offset[0]) ||
                   (size == SZ_WORD && offset == 2'b00));
  end
endmodule

// File: rtl/data_mem_param.sv
// data_mem_param: 3-state stalling data memory with sub-word access and LED register
module data_mem_param
  import data_mem_param_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT,
  parameter int          LED_WIDTH   = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 misaligned
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] a, wd, word_buf, ld, merged;
  logic [3:0] sm;
  logic wr, rd, lane_mis, led_hit, bad;
  logic [LED_WIDTH-1:0] led_reg;
  logic [IDX_W-1:0] idx;
  data_mem_param_lane_fmt u_fmt (
    .word(word_buf), .offset(a[1:0]), .size(sm[2:0]), .sign(sm[3]), .store(wd),
    .load(ld), .merged(merged), .misaligned(lane_mis)
  );
  assign idx = a[IDX_W+1:2];
  assign led_hit = a == LED_ADDR;
  assign bad = lane_mis | (led_hit & (sm[2:0] != SZ_WORD));
  assign led = led_reg;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? ((memread | memwrite) ? FETCH : IDLE) :
              state == FETCH ? COMMIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_stall  <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
      led_reg    <= '0;
    end else if (state == IDLE) begin
      misaligned <= 1'b0;
      if (memread | memwrite) begin
        a         <= addr;
        wd        <= write_data;
        sm        <= sign_mask;
        wr        <= memwrite;
        rd        <= memread & ~memwrite;
        clk_stall <= 1'b1;
      end
    end else if (state == COMMIT) begin
      clk_stall  <= 1'b0;
      misaligned <= bad;
      if (!bad && wr && led_hit) led_reg <= wd[LED_WIDTH-1:0];
      if (!bad && rd) read_data <= led_hit ? 32'(led_reg) : ld;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state == FETCH) word_buf <= mem[idx];
    if (!rst && state == COMMIT && wr && !bad && !led_hit) mem[idx] <= merged;
  end
endmodule
